// File: rtl/tft_fill_engine_if.sv
// tft_fill_engine_if
// Bundles every signal of the fill engine except clk/rst.
//   Command side : cmd_valid/cmd_ready handshake, rectangle corners, mode,
//                  two RGB565 colours, cmd_err reject pulse, done pulse.
//   Panel side   : init_done/drv_busy status, win_set_stb/stream_start strobes,
//                  latched window win_*, pixel stream pix_data/pix_valid/pix_ready.
// The engine connects through modport slave; the driver of commands and the
// model of the downstream panel (e.g. a testbench) use modport master.
interface tft_fill_engine_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_x0;
    logic [15:0] cmd_y0;
    logic [15:0] cmd_x1;
    logic [15:0] cmd_y1;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_color_a;
    logic [15:0] cmd_color_b;
    logic        cmd_err;
    logic        done;
    logic        init_done;
    logic        drv_busy;
    logic        win_set_stb;
    logic        stream_start;
    logic [15:0] win_x0;
    logic [15:0] win_y0;
    logic [15:0] win_x1;
    logic [15:0] win_y1;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_mode,
               cmd_color_a, cmd_color_b, init_done, drv_busy, pix_ready,
        output cmd_ready, cmd_err, done, win_set_stb, stream_start,
               win_x0, win_y0, win_x1, win_y1, pix_data, pix_valid
    );

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_mode,
               cmd_color_a, cmd_color_b, init_done, drv_busy, pix_ready,
        input  cmd_ready, cmd_err, done, win_set_stb, stream_start,
               win_x0, win_y0, win_x1, win_y1, pix_data, pix_valid
    );
endinterface

// File: rtl/tft_fill_engine.sv
// tft_fill_engine
// Accepts a rectangle fill command, clamps it to the panel, programs the
// panel window, starts a memory-write stream and emits one RGB565 pixel per
// accepted transfer in raster order (solid, checkerboard or vertical bars).
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - tft_fill_engine_if.slave (command handshake, panel strobes,
//          window and pixel stream)
module tft_fill_engine #(
    parameter int X_RES    = 240,
    parameter int Y_RES    = 320,
    parameter int CHK_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    tft_fill_engine_if.slave  bus
);
    localparam logic [15:0] X_MAX = 16'(X_RES - 1);
    localparam logic [15:0] Y_MAX = 16'(Y_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WIN, S_WIN_WAIT, S_MEMWR, S_MEM_WAIT, S_STREAM, S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] color_a_q, color_a_d, color_b_q, color_b_d;
    logic [15:0] col_q, col_d, row_q, row_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic        cmd_err_q, cmd_err_d;
    logic        done_q, done_d;
    // Shared one-bit wait counter for WIN_WAIT, MEM_WAIT and DRAIN.
    logic        wait_q, wait_d;

    logic [15:0] x1_clamp, y1_clamp, next_col, next_row, pix_col, pix_row;
    logic [15:0] cx, cy, color;
    logic        last_col, last_row, xfer, tile_x, tile_y, bad_cmd;

    assign bus.cmd_ready    = (state_q == S_IDLE) && bus.init_done && !rst;
    assign bus.cmd_err      = cmd_err_q;
    assign bus.done         = done_q;
    assign bus.win_set_stb  = (state_q == S_WIN);
    assign bus.stream_start = (state_q == S_MEMWR);
    assign bus.win_x0       = x0_q;
    assign bus.win_y0       = y0_q;
    assign bus.win_x1       = x1_q;
    assign bus.win_y1       = y1_q;
    assign bus.pix_data     = pix_data_q;
    assign bus.pix_valid    = pix_valid_q;

    // State and datapath registers; everything returns to zero/IDLE at once on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            mode_q      <= '0;
            color_a_q   <= '0;
            color_b_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            done_q      <= 1'b0;
            wait_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            mode_q      <= mode_d;
            color_a_q   <= color_a_d;
            color_b_q   <= color_b_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            cmd_err_q   <= cmd_err_d;
            done_q      <= done_d;
            wait_q      <= wait_d;
        end
    end

    // Next-state, raster walk and pixel colour. The colour is computed for
    // the coordinate that will be on the bus next cycle: the window origin
    // when entering STREAM, otherwise the successor of the current pixel.
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        mode_d      = mode_q;
        color_a_d   = color_a_q;
        color_b_d   = color_b_q;
        col_d       = col_q;
        row_d       = row_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        cmd_err_d   = 1'b0;
        done_d      = 1'b0;
        wait_d      = wait_q;

        x1_clamp = (x1_q > X_MAX) ? X_MAX : x1_q;
        y1_clamp = (y1_q > Y_MAX) ? Y_MAX : y1_q;
        bad_cmd  = (x0_q > x1_clamp) || (y0_q > y1_clamp) || (mode_q == 2'd3);

        last_col = (col_q == x1_q);
        last_row = (row_q == y1_q);
        xfer     = pix_valid_q && bus.pix_ready;
        next_col = last_col ? x0_q : col_q + 16'd1;
        next_row = last_col ? row_q + 16'd1 : row_q;

        pix_col = (state_q == S_STREAM) ? next_col : col_q;
        pix_row = (state_q == S_STREAM) ? next_row : row_q;
        cx      = pix_col - x0_q;
        cy      = pix_row - y0_q;
        tile_x  = ((cx >> CHK_LOG2) & 16'd1) != 16'd0;
        tile_y  = ((cy >> CHK_LOG2) & 16'd1) != 16'd0;
        case (mode_q)
            2'd1:    color = (tile_x ^ tile_y) ? color_b_q : color_a_q;
            2'd2:    color = tile_x ? color_b_q : color_a_q;
            default: color = color_a_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    x0_d      = bus.cmd_x0;
                    y0_d      = bus.cmd_y0;
                    x1_d      = bus.cmd_x1;
                    y1_d      = bus.cmd_y1;
                    mode_d    = bus.cmd_mode;
                    color_a_d = bus.cmd_color_a;
                    color_b_d = bus.cmd_color_b;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                x1_d  = x1_clamp;
                y1_d  = y1_clamp;
                col_d = x0_q;
                row_d = y0_q;
                if (bad_cmd) begin
                    cmd_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WIN;
                end
            end
            S_WIN: begin
                wait_d  = 1'b0;
                state_d = S_WIN_WAIT;
            end
            // First cycle after the strobe ignores drv_busy so the driver has time to raise it.
            S_WIN_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (!bus.drv_busy) begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMWR: begin
                wait_d  = 1'b0;
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = color;
                    state_d     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    if (last_col && last_row) begin
                        pix_valid_d = 1'b0;
                        wait_d      = 1'b0;
                        state_d     = S_DRAIN;
                    end else begin
                        col_d      = next_col;
                        row_d      = next_row;
                        pix_data_d = color;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.drv_busy) begin
                    wait_d = 1'b0;
                end else if (wait_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tft_fill_engine.sv
// tb_tft_fill_engine
// Self-checking bench for tft_fill_engine on a small 40x24 panel. A monitor
// compares every pixel transfer against a queue of expected pixels built by
// walking the clamped rectangle, and checks handshake, strobe and window
// behaviour each cycle; directed cases pin literal values, then random
// commands run with random pix_ready/drv_busy behaviour.
module tb_tft_fill_engine;
    localparam int XR = 40;
    localparam int YR = 24;
    localparam int K  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tft_fill_engine_if bus ();

    tft_fill_engine #(.X_RES(XR), .Y_RES(YR), .CHK_LOG2(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_pix[$];
    logic [15:0] got[$];
    logic [63:0] ew;
    logic [63:0] cap_win;
    bit          exp_bad;
    int          exp_area;
    int          n_xfer, n_win, n_start, n_done, n_err;
    bit          idle_m = 1'b1;
    bit          win_active, prev_hold, prev_more, prev_last;
    logic [15:0] prev_data;
    int          pr_mode = 0;
    bit          busy_en = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference colour rule: tile index parity of the local offsets.
    function automatic logic [15:0] pixColor(input int m, input int cx, input int cy,
                                             input logic [15:0] a, input logic [15:0] b);
        int tx;
        int ty;
        tx = (cx >> K) & 1;
        ty = (cy >> K) & 1;
        if (m == 1) return ((tx ^ ty) != 0) ? b : a;
        if (m == 2) return (tx != 0) ? b : a;
        return a;
    endfunction

    // Downstream behaviour: pix_ready pattern and occasional busy.
    always @(posedge clk) begin
        #1;
        case (pr_mode)
            0:       bus.pix_ready = 1'b1;
            1:       bus.pix_ready = ~bus.pix_ready;
            default: bus.pix_ready = 1'($urandom_range(0, 1));
        endcase
        bus.drv_busy = busy_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst) begin
            idle_m     = 1'b1;
            win_active = 1'b0;
            prev_hold  = 1'b0;
            prev_more  = 1'b0;
            prev_last  = 1'b0;
        end else begin
            if (bus.done || bus.cmd_err) idle_m = 1'b1;
            if (bus.done) n_done++;
            if (bus.cmd_err) n_err++;
            checkOutput("cmd_ready", 64'(bus.cmd_ready), 64'(idle_m && bus.init_done));
            if (bus.cmd_valid && bus.cmd_ready) idle_m = 1'b0;
            if (win_active)
                checkOutput("win_stable", {bus.win_x0, bus.win_y0, bus.win_x1, bus.win_y1}, ew);
            if (bus.win_set_stb) begin
                n_win++;
                cap_win = {bus.win_x0, bus.win_y0, bus.win_x1, bus.win_y1};
                checkOutput("win_strobe", cap_win, ew);
                win_active = 1'b1;
            end
            if (bus.stream_start) n_start++;
            if (prev_hold) begin
                checkOutput("hold_valid", 64'(bus.pix_valid), 64'd1);
                checkOutput("hold_data", 64'(bus.pix_data), 64'(prev_data));
            end
            if (prev_more) checkOutput("valid_gap", 64'(bus.pix_valid), 64'd1);
            if (prev_last) checkOutput("valid_after_last", 64'(bus.pix_valid), 64'd0);
            if (bus.pix_valid) checkOutput("pix_before_start", 64'(n_start), 64'd1);
            prev_hold = bus.pix_valid && !bus.pix_ready;
            prev_data = bus.pix_data;
            prev_more = 1'b0;
            prev_last = 1'b0;
            if (bus.pix_valid && bus.pix_ready) begin
                n_xfer++;
                got.push_back(bus.pix_data);
                if (exp_pix.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_pix: got 0x%0h, expected no pixel at %0t", bus.pix_data, $time);
                end else begin
                    checkOutput("pix_data", 64'(bus.pix_data), 64'(exp_pix.pop_front()));
                    prev_more = exp_pix.size() != 0;
                    prev_last = !prev_more;
                end
            end
            if (bus.done) win_active = 1'b0;
        end
    end

    // Build expectations for a command, then hand it to the engine.
    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1, input int m,
                                 input logic [15:0] a, input logic [15:0] b);
        int cx1;
        int cy1;
        int tries;
        cx1 = (x1 > XR - 1) ? XR - 1 : x1;
        cy1 = (y1 > YR - 1) ? YR - 1 : y1;
        exp_bad = (x0 > cx1) || (y0 > cy1) || (m == 3);
        ew = {16'(x0), 16'(y0), 16'(cx1), 16'(cy1)};
        exp_pix.delete();
        got.delete();
        exp_area = 0;
        if (!exp_bad) begin
            exp_area = (cx1 - x0 + 1) * (cy1 - y0 + 1);
            for (int r = y0; r <= cy1; r++)
                for (int c = x0; c <= cx1; c++)
                    exp_pix.push_back(pixColor(m, c - x0, r - y0, a, b));
        end
        n_xfer = 0; n_win = 0; n_start = 0; n_done = 0; n_err = 0;
        bus.cmd_x0 = 16'(x0);
        bus.cmd_y0 = 16'(y0);
        bus.cmd_x1 = 16'(x1);
        bus.cmd_y1 = 16'(y1);
        bus.cmd_mode = 2'(m);
        bus.cmd_color_a = a;
        bus.cmd_color_b = b;
        tries = 0;
        while (!bus.cmd_ready && tries < 200) begin
            @(posedge clk);
            #1;
            tries++;
        end
        checkOutput("cmd_accept_wait", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitEnd();
        int budget;
        budget = exp_area * 6 + 200;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_done + n_err != 0) break;
        end
        checkOutput("finish", 64'(n_done + n_err != 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkCommand();
        if (exp_bad) begin
            checkOutput("err_pulse", 64'(n_err), 64'd1);
            checkOutput("err_no_win", 64'(n_win), 64'd0);
            checkOutput("err_no_start", 64'(n_start), 64'd0);
            checkOutput("err_no_pix", 64'(n_xfer), 64'd0);
            checkOutput("err_no_done", 64'(n_done), 64'd0);
        end else begin
            checkOutput("win_count", 64'(n_win), 64'd1);
            checkOutput("start_count", 64'(n_start), 64'd1);
            checkOutput("done_count", 64'(n_done), 64'd1);
            checkOutput("no_err", 64'(n_err), 64'd0);
            checkOutput("xfer_count", 64'(n_xfer), 64'(exp_area));
            checkOutput("pix_left", 64'(exp_pix.size()), 64'd0);
        end
    endtask

    task automatic runCmd(input int x0, input int y0, input int x1, input int y1, input int m,
                          input logic [15:0] a, input logic [15:0] b);
        applyStimulus(x0, y0, x1, y1, m, a, b);
        waitEnd();
        checkCommand();
    endtask

    task automatic waitXfers(input int n);
        for (int i = 0; i < 4000 && n_xfer < n; i++) @(posedge clk);
        #1;
        checkOutput("reach_xfers", 64'(n_xfer >= n), 64'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
        bus.cmd_mode = '0; bus.cmd_color_a = '0; bus.cmd_color_b = '0;
        bus.init_done = 1'b0;
        bus.drv_busy = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_outputs", {bus.pix_valid, bus.cmd_ready, bus.done, bus.cmd_err,
                                    bus.win_set_stb, bus.stream_start}, 64'd0);
        checkOutput("rst_pix_data", 64'(bus.pix_data), 64'd0);
        checkOutput("rst_win", {bus.win_x0, bus.win_y0, bus.win_x1, bus.win_y1}, 64'd0);
        rst = 1'b0;

        // Command offered before the panel is ready must wait.
        bus.cmd_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("no_accept_before_init", 64'(bus.cmd_ready), 64'd0);
        bus.cmd_valid = 1'b0;
        bus.init_done = 1'b1;
        @(posedge clk);
        #1;

        runCmd(0, 0, 1, 1, 0, 16'hF800, 16'h0000);
        checkOutput("solid_win_lit", cap_win, {16'd0, 16'd0, 16'd1, 16'd1});
        checkOutput("solid_xfer_lit", 64'(n_xfer), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput("solid_pix_lit", 64'(got[i]), 64'hF800);

        runCmd(0, 0, 15, 0, 1, 16'hFFFF, 16'h0000);
        checkOutput("chk_pix7_lit", 64'(got[7]), 64'hFFFF);
        checkOutput("chk_pix8_lit", 64'(got[8]), 64'h0000);
        checkOutput("chk_pix15_lit", 64'(got[15]), 64'h0000);

        pr_mode = 1;
        runCmd(3, 2, 12, 6, 2, 16'h07E0, 16'h001F);
        checkOutput("bars_xfer_lit", 64'(n_xfer), 64'd50);
        pr_mode = 0;

        runCmd(10, 5, 300, 400, 1, 16'h1234, 16'h4321);
        checkOutput("clamp_win_lit", cap_win, {16'd10, 16'd5, 16'd39, 16'd23});
        checkOutput("clamp_xfer_lit", 64'(n_xfer), 64'd570);
        runCmd(5, 0, 4, 0, 0, 16'hAAAA, 16'h5555);
        runCmd(0, 0, 3, 3, 3, 16'hAAAA, 16'h5555);
        runCmd(7, 9, 7, 9, 1, 16'hBEEF, 16'h0001);
        checkOutput("single_xfer_lit", 64'(n_xfer), 64'd1);

        // Stray command during streaming is ignored.
        applyStimulus(2, 2, 21, 11, 1, 16'h0F0F, 16'hF0F0);
        waitXfers(6);
        bus.cmd_x0 = 16'd1; bus.cmd_mode = 2'd0;
        bus.cmd_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        waitEnd();
        checkCommand();

        // init_done dropping mid-fill does not abort it.
        busy_en = 1'b1;
        applyStimulus(0, 0, 19, 9, 2, 16'hCAFE, 16'h0BAD);
        waitXfers(10);
        bus.init_done = 1'b0;
        waitEnd();
        checkCommand();
        bus.init_done = 1'b1;
        busy_en = 1'b0;

        runCmd(0, 0, 65535, 65535, 0, 16'h7777, 16'h0000);
        checkOutput("full_xfer_lit", 64'(n_xfer), 64'(XR * YR));

        // Reset in the middle of a stream.
        applyStimulus(0, 0, 39, 23, 1, 16'h1111, 16'h2222);
        waitXfers(30);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_outputs", {bus.pix_valid, bus.cmd_ready, bus.done,
                                       bus.win_set_stb, bus.stream_start}, 64'd0);
        checkOutput("midrst_win", {bus.win_x0, bus.win_y0, bus.win_x1, bus.win_y1}, 64'd0);
        exp_pix.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        runCmd(4, 4, 9, 6, 0, 16'h5A5A, 16'h0000);

        // Randomized commands against the reference model.
        for (int t = 0; t < 25; t++) begin
            pr_mode = int'($urandom_range(0, 2));
            busy_en = 1'($urandom_range(0, 1));
            runCmd(int'($urandom_range(0, 45)), int'($urandom_range(0, 28)),
                   int'($urandom_range(0, 50)), int'($urandom_range(0, 30)),
                   int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
